// File: rtl/collide_pair_engine.sv
// rtl/collide_pair_engine.sv - pairwise AABB overlap walker answering the reset controller's pulse handshake
// Define COLLIDE_2D_EN to add the y-axis to the overlap test; default build tests x only.
module collide_pair_engine #(
  parameter int COORD_W = 8,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 flagRst2,
  input  logic                 cs,
  input  logic                 rst_in,
  input  logic [IDX_W:0]       obj_count,
  output logic [IDX_W-1:0]     mem_addr,
  output logic                 mem_rd,
  input  logic [4*COORD_W-1:0] mem_rdata,
  output logic                 busy,
  output logic                 hit_valid,
  output logic [IDX_W-1:0]     hit_a,
  output logic [IDX_W-1:0]     hit_b,
  output logic [CNT_W-1:0]     hit_count,
  output logic                 done_collide
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_CMP, S_DONE
  } state_t;

  localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] TWO = (IDX_W+1)'(2);

`ifdef COLLIDE_2D_EN
  localparam int BOX_W = 4*COORD_W;
`else
  localparam int BOX_W = 2*COORD_W;
  logic w_unused_y;
  assign w_unused_y = ^mem_rdata[2*COORD_W-1:0];
`endif

  state_t              r_state, w_next;
  logic                r_sync1, r_rs, r_rs_d;
  logic [IDX_W:0]      r_n, r_i, r_j;
  logic [BOX_W-1:0]    r_box_a, r_box_b;
  logic [CNT_W-1:0]    r_hit_count;
  logic                r_done;
  logic                w_clear, w_start, w_overlap, w_j_more, w_i_more;

  // Both sync stages reset high so a released reset never looks like a rising edge.
  always_ff @(posedge clk or posedge flagRst2) begin
    if (flagRst2) begin
      r_sync1 <= 1'b1;
      r_rs    <= 1'b1;
      r_rs_d  <= 1'b1;
    end else begin
      r_sync1 <= rst_in;
      r_rs    <= r_sync1;
      r_rs_d  <= r_rs;
    end
  end

  assign w_clear = cs & ~r_rs;
  assign w_start = cs & r_rs & ~r_rs_d;

  assign w_overlap = (r_box_a[BOX_W-1 -: COORD_W] <= r_box_b[BOX_W-COORD_W-1 -: COORD_W]) &&
                     (r_box_b[BOX_W-1 -: COORD_W] <= r_box_a[BOX_W-COORD_W-1 -: COORD_W])
`ifdef COLLIDE_2D_EN
                  && (r_box_a[2*COORD_W-1 -: COORD_W] <= r_box_b[COORD_W-1:0])
                  && (r_box_b[2*COORD_W-1 -: COORD_W] <= r_box_a[COORD_W-1:0])
`endif
                  ;

  assign w_j_more = (r_j < (r_n - ONE));
  assign w_i_more = (r_i < (r_n - TWO));

  always_ff @(posedge clk or posedge flagRst2) begin
    if (flagRst2) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_rd    = 1'b0;
    hit_valid = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_IDLE;
      S_RD_A:   begin mem_rd = 1'b1; w_next = S_WAIT_A; end
      S_WAIT_A: w_next = S_RD_B;
      S_RD_B:   begin mem_rd = 1'b1; w_next = S_WAIT_B; end
      S_WAIT_B: w_next = S_CMP;
      S_CMP: begin
        hit_valid = w_overlap;
        if (w_j_more)      w_next = S_RD_B;
        else if (w_i_more) w_next = S_RD_A;
        else               w_next = S_DONE;
      end
      S_DONE:   w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
    if (w_start) w_next = (obj_count < TWO) ? S_DONE : S_RD_A;
    // Clear dominates: the aborted cycle must not report a hit or read memory.
    if (w_clear) begin
      w_next    = S_IDLE;
      hit_valid = 1'b0;
      mem_rd    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge flagRst2) begin
    if (flagRst2) begin
      r_n         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_box_a     <= '0;
      r_box_b     <= '0;
      r_hit_count <= '0;
      r_done      <= 1'b0;
    end else if (w_clear) begin
      r_hit_count <= '0;
      r_done      <= 1'b0;
    end else if (w_start) begin
      r_n         <= obj_count;
      r_i         <= '0;
      r_j         <= ONE;
      r_hit_count <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_A: r_box_a <= mem_rdata[4*COORD_W-1 -: BOX_W];
        S_WAIT_B: r_box_b <= mem_rdata[4*COORD_W-1 -: BOX_W];
        S_CMP: begin
          if (w_overlap && (r_hit_count != {CNT_W{1'b1}}))
            r_hit_count <= r_hit_count + 1'b1;
          if (w_j_more) begin
            r_j <= r_j + ONE;
          end else if (w_i_more) begin
            r_i <= r_i + ONE;
            r_j <= r_i + TWO;
          end
        end
        S_DONE:   r_done <= 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    if (r_state == S_RD_A || r_state == S_WAIT_A)      mem_addr = r_i[IDX_W-1:0];
    else if (r_state == S_RD_B || r_state == S_WAIT_B) mem_addr = r_j[IDX_W-1:0];
  end

  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign hit_a        = r_i[IDX_W-1:0];
  assign hit_b        = r_j[IDX_W-1:0];
  assign hit_count    = r_hit_count;
  assign done_collide = r_done;

endmodule

// File: tb/tb_collide_pair_engine.sv
// tb/tb_collide_pair_engine.sv - scoreboard bench for collide_pair_engine
module tb_collide_pair_engine;
  localparam int CW = 8;
  localparam int IW = 4;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          flagRst2, cs, rst_in;
  logic [IW:0]   obj_count;
  logic [IW-1:0] mem_addr;
  logic          mem_rd;
  logic [4*CW-1:0] mem_rdata = '0;
  logic          busy, hit_valid, done_collide;
  logic [IW-1:0] hit_a, hit_b;
  logic [NW-1:0] hit_count;

  logic [4*CW-1:0] mem [16];
  int checks = 0;
  int errors = 0;
  int rd_seen = 0;
  int exp_a[$];
  int exp_b[$];

  collide_pair_engine #(.COORD_W(CW), .IDX_W(IW), .CNT_W(NW)) dut (
    .clk(clk), .flagRst2(flagRst2), .cs(cs), .rst_in(rst_in),
    .obj_count(obj_count), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .busy(busy), .hit_valid(hit_valid),
    .hit_a(hit_a), .hit_b(hit_b), .hit_count(hit_count),
    .done_collide(done_collide)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [4*CW-1:0] box(input int x0, input int x1, input int y0, input int y1);
    return {8'(x0), 8'(x1), 8'(y0), 8'(y1)};
  endfunction

  // Monitor: every hit pulse must match the next expected pair.
  always @(negedge clk) begin
    int ea, eb;
    if (mem_rd) rd_seen++;
    if (hit_valid === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit actual=(%0d,%0d) expected=none", hit_a, hit_b);
      end else begin
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        check("hit_a", int'(hit_a), ea);
        check("hit_b", int'(hit_b), eb);
      end
    end
  end

  task automatic push_hit(input int a, input int b);
    exp_a.push_back(a);
    exp_b.push_back(b);
  endtask

  // Low pulse then rising edge; latency counted from the start-detect cycle.
  task automatic run_job(input int n, input int low_cyc, input int exp_lat, input int exp_cnt, input string tag);
    int cnt;
    obj_count = (IW+1)'(n);
    @(negedge clk);
    rst_in = 1'b0;
    repeat (low_cyc) @(negedge clk);
    check({tag, "_clr_done"}, int'(done_collide), 0);
    check({tag, "_clr_count"}, int'(hit_count), 0);
    rst_in = 1'b1;
    cnt = 0;
    while (cnt < 2000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (done_collide) break;
    end
    check({tag, "_latency"}, cnt - 2, exp_lat);
    check({tag, "_hit_count"}, int'(hit_count), exp_cnt);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pending_hits"}, exp_a.size(), 0);
  endtask

  initial begin
    int cnt;
    int exp3;
    flagRst2 = 1'b1;
    cs = 1'b1;
    rst_in = 1'b1;
    obj_count = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    flagRst2 = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done_collide), 0);
    check("rst_count", int'(hit_count), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_addr", int'(mem_addr), 0);

    // Reset during the first RD_B of an N=4 job.
    mem[0] = box(0, 9, 0, 9);
    mem[1] = box(5, 9, 0, 9);
    mem[2] = box(5, 9, 0, 9);
    mem[3] = box(5, 9, 0, 9);
    obj_count = 5'd4;
    rst_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (mem_rd && mem_addr == 4'd1) break;
    end
    check("midrst_reached_rd_b", int'(cnt < 200), 1);
    flagRst2 = 1'b1;
    @(negedge clk);
    flagRst2 = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_mem_rd", int'(mem_rd), 0);
    check("midrst_addr", int'(mem_addr), 0);
    check("midrst_done", int'(done_collide), 0);
    check("midrst_count", int'(hit_count), 0);
    rd_seen = 0;
    repeat (20) @(negedge clk);
    check("midrst_no_reads", rd_seen, 0);

    // Controller sequence, N=3.
    mem[0] = box(10, 20, 0, 5);
    mem[1] = box(15, 30, 10, 12);
    mem[2] = box(30, 50, 0, 5);
`ifdef COLLIDE_2D_EN
    exp3 = 0;
`else
    exp3 = 2;
    push_hit(0, 1);
    push_hit(1, 2);
`endif
    run_job(3, 3, 15, exp3, "n3");

    // Acknowledge and restart: same pass again.
`ifndef COLLIDE_2D_EN
    push_hit(0, 1);
    push_hit(1, 2);
`endif
    run_job(3, 3, 15, exp3, "n3_restart");

    // cs low: pulse must be ignored entirely.
    @(negedge clk);
    cs = 1'b0;
    rst_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    repeat (8) @(negedge clk);
    cs = 1'b1;
    rd_seen = 0;
    repeat (5) @(negedge clk);
    check("csgate_done", int'(done_collide), 1);
    check("csgate_count", int'(hit_count), exp3);
    check("csgate_busy", int'(busy), 0);
    check("csgate_no_reads", rd_seen, 0);

    // Degenerate counts.
    rd_seen = 0;
    run_job(1, 3, 2, 0, "n1");
    check("n1_no_reads", rd_seen, 0);
    rd_seen = 0;
    run_job(0, 3, 2, 0, "n0");
    check("n0_no_reads", rd_seen, 0);

    // Full memory of identical boxes: every pair hits.
    for (int k = 0; k < 16; k++) mem[k] = box(40, 60, 40, 60);
    for (int a = 0; a < 15; a++)
      for (int b = a + 1; b < 16; b++) push_hit(a, b);
    run_job(16, 3, 392, 120, "n16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
